// File: rtl/accel_mac_engine_if.sv
// Operand and command bus between the TinyQV accelerator register block
// (master) and the MAC engine (slave).
interface accel_mac_engine_if #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ACC_W      = 20
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Operand push channel
  logic             op_valid;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic             op_ready;

  // Command channel
  logic             cmd_start;
  logic [3:0]       cmd_len;
  logic             cmd_clear;

  // Status and result
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] result;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output op_valid, op_a, op_b, cmd_start, cmd_len, cmd_clear,
    input  op_ready, busy, done, result, fifo_level
  );

  modport slave (
    input  op_valid, op_a, op_b, cmd_start, cmd_len, cmd_clear,
    output op_ready, busy, done, result, fifo_level
  );
endinterface

// File: rtl/accel_mac_engine.sv
// Dot-product MAC engine: buffers 8-bit unsigned operand pairs in a small
// FIFO and accumulates a*b over a commanded number of pairs, one per clock.
module accel_mac_engine #(
  parameter int unsigned FIFO_DEPTH = 4,   // power of two
  parameter int unsigned ACC_W      = 20
) (
  input logic                clk,
  input logic                rst_n,
  accel_mac_engine_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic              busy_q;
  logic              done_q;
  logic [ACC_W-1:0]  result_q;
  logic [3:0]        remaining;

  logic [15:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [15:0]       head;
  logic [15:0]       prod;

  assign full  = (count == LVL_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // op_ready is based on current occupancy only; a full FIFO refuses a push
  // even if it pops in the same cycle. A clear discards any same-cycle push.
  assign push = bus.op_valid && !full && !bus.cmd_clear;
  assign pop  = (state == S_RUN) && !empty && (remaining != '0) && !bus.cmd_clear;

  assign head = mem[rd_ptr];
  assign prod = 16'(head[15:8]) * 16'(head[7:0]);

  assign bus.op_ready   = !full;
  assign bus.fifo_level = count;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;

  // FIFO storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.op_a, bus.op_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.cmd_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + LVL_W'(1);
      end else if (pop && !push) begin
        count <= count - LVL_W'(1);
      end
    end
  end

  // Control FSM with registered busy/done, accumulator and pair countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      remaining <= '0;
    end else if (bus.cmd_clear) begin
      state     <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      remaining <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.cmd_start) begin
            result_q <= '0;
            if (bus.cmd_len != '0) begin
              remaining <= bus.cmd_len;
              busy_q    <= 1'b1;
              state     <= S_RUN;
            end else begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (pop) begin
            result_q  <= result_q + ACC_W'(prod);
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/accel_mac_engine.md
Name: accel_mac_engine

Overview:
- Downstream compute stage of the TinyQV accelerator peripheral.
- The peripheral's register interface pushes 8-bit operand pairs and issues commands; this block buffers the pairs in a 4-entry FIFO and runs an unsigned dot-product multiply-accumulate over a commanded number of pairs.
- It returns a 20-bit result plus busy/done status for the peripheral to expose on data_out.

Parameters:
- FIFO_DEPTH, 4, number of operand-pair entries; must be a power of two.
- ACC_W, 20, accumulator/result width; sized so 15 x 255 x 255 = 975375 cannot overflow.

Ports:
- clk  input  1  project clock, nominal 64 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- op_valid  input  1  operand pair present on op_a/op_b.
- op_a  input  8  operand A, unsigned.
- op_b  input  8  operand B, unsigned.
- op_ready  output  1  FIFO can accept a pair; equals !full.
- cmd_start  input  1  single-cycle pulse that begins a run.
- cmd_len  input  4  number of pairs to consume, 0..15; sampled on cmd_start.
- cmd_clear  input  1  single-cycle pulse that aborts, flushes the FIFO and zeroes the result.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a run completes.
- result  output  ACC_W  accumulator value.
- fifo_level  output  3  current FIFO occupancy, 0..4.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, fifo_level=0, op_ready=1, state IDLE, busy=0, done=0, result=0, remaining-count=0.
- Push: occurs on a cycle where op_valid && op_ready. op_ready does not look ahead to a same-cycle pop, so a full FIFO refuses a push even if it pops that cycle.
- Pop: occurs in RUN when the FIFO is not empty and remaining>0.
- Push and pop in the same cycle leave fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, RUN, DONE.
- IDLE + cmd_start, cmd_len>0: result<=0, remaining<=cmd_len, go to RUN. busy goes high the next cycle.
- IDLE + cmd_start, cmd_len=0: result<=0, go to DONE. done pulses one cycle later.
- RUN, each pop cycle: result <= result + op_a*op_b (16-bit product zero-extended to ACC_W), remaining <= remaining-1. Throughput is one pair per clock.
- RUN with the FIFO empty: stall; hold result and remaining; busy stays 1.
- RUN, pop that takes remaining from 1 to 0: next state DONE.
- DONE: done=1 for exactly one cycle, busy=0, then unconditionally IDLE.
- Latency: the result including the last pair is visible in the same cycle done is high, i.e. one clock after the last pop edge.
- result holds its value in IDLE until the next cmd_start or cmd_clear.
- cmd_start while in RUN or DONE: ignored; cmd_len is not resampled.
- cmd_clear, any state: next cycle FIFO empty, result=0, remaining=0, state IDLE, no done pulse. A push in the same cycle is discarded.
- cmd_clear and cmd_start together: cmd_clear wins and the start is dropped.
- Leftover FIFO entries after a run remain queued for the next run.
- Reset asserted mid-RUN: immediate return to reset values, no done pulse.
- Arithmetic is purely unsigned, with no saturation or overflow flag.

Test Plan:
- Basic run: push (3,4),(5,6),(7,8) with cmd_len=3, then start -> three pop cycles, done pulse, result=12+30+56=98, busy low afterwards.
- Full/backpressure: with no run active, push 5 pairs back-to-back -> op_ready=0 after the 4th, fifo_level=4, 5th pair not accepted. Then start with len=4 on (255,255)x4 -> result=260100.
- Stall: start with len=2 and an empty FIFO -> busy=1, result stays 0. Push (2,2), wait 3 cycles, push (9,9) -> done pulse, result=85.
- Zero length: cmd_start with cmd_len=0 -> done one cycle later, result=0, fifo_level unchanged.
- Abort: mid-run with 2 pairs queued, pulse cmd_clear -> next cycle busy=0, fifo_level=0, result=0, no done pulse. A simultaneous cmd_start is ignored.
- Max accumulate and async reset: len=15, all pairs (255,255) -> result=975375, no wrap. Repeat, and drop rst_n asynchronously at pair 7 -> result=0, busy=0, op_ready=1 before the next clock edge.
